// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, write-mode encodings and mstatus constants
package csr_pkg;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;
   localparam logic [1:0] WSC_WRITE = 2'b01;
   localparam logic [1:0] WSC_SET   = 2'b10;
   localparam logic [1:0] WSC_CLR   = 2'b11;
   localparam logic [31:0] MSTATUS_RST  = 32'h0000_0088;
   localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;
   function automatic logic [31:0] wsc_apply(input logic [1:0] mode, input logic [31:0] old, input logic [31:0] wd);
      return mode == WSC_SET ? old | wd : mode == WSC_CLR ? old & ~wd : wd;
   endfunction
endpackage

// File: rtl/csr_addr_decode.sv
// csr_addr_decode: maps a 12-bit CSR address to {valid, 4-bit index}
module csr_addr_decode (
   input  logic [11:0] addr,
   output logic        valid,
   output logic [3:0]  idx
);
   assign valid = addr[11:7] == 5'h06 && addr[5:3] == 3'b000;
   assign idx = {addr[6], addr[2:0]};
endmodule

// File: rtl/csr_regs.sv
// csr_regs: 16 x 32-bit machine CSRs with write/set/clear; CSR_MSTATUS_MASK_EN masks mstatus writes
module csr_regs
   import csr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_w,
   input  logic [11:0] raddr,
   input  logic [11:0] waddr,
   input  logic [31:0] wdata,
   input  logic [1:0]  csr_wsc_mode,
   output logic [31:0] rdata,
   output logic [31:0] mstatus
);
   logic [31:0] regs [16];
   logic        rv, wv;
   logic [3:0]  ridx, widx;
   logic [31:0] nv, wval;
   csr_addr_decode u_rdec (.addr(raddr), .valid(rv), .idx(ridx));
   csr_addr_decode u_wdec (.addr(waddr), .valid(wv), .idx(widx));
   assign nv = wsc_apply(csr_wsc_mode, regs[widx], wdata);
`ifdef CSR_MSTATUS_MASK_EN
   assign wval = widx == 4'd0 ? nv & MSTATUS_MASK : nv;
`else
   assign wval = nv;
`endif
   always_ff @(posedge clk) begin
      if (!rst)
         for (int i = 0; i < 16; i++) regs[i] <= i == 0 ? MSTATUS_RST : 32'h0;
      else if (csr_w && wv)
         regs[widx] <= wval;
   end
   assign rdata = rv ? regs[ridx] : 32'h0;
   assign mstatus = regs[0];
endmodule

// File: tb/tb_csr_regs.sv
// tb_csr_regs: directed and random stimulus checked against an array model of the CSR file
module tb_csr_regs;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        csr_w = 1'b0;
   logic [11:0] raddr = 12'h0;
   logic [11:0] waddr = 12'h0;
   logic [31:0] wdata = 32'h0;
   logic [1:0]  csr_wsc_mode = 2'b00;
   logic [31:0] rdata, mstatus;
   csr_regs dut (
      .clk(clk), .rst(rst), .csr_w(csr_w), .raddr(raddr), .waddr(waddr),
      .wdata(wdata), .csr_wsc_mode(csr_wsc_mode), .rdata(rdata), .mstatus(mstatus)
   );
   always #5 clk = ~clk;
   logic [31:0] m [16];
   bit          ready = 0;
   bit          lit_on = 0;
   logic [31:0] lit_rd, lit_ms;
   string       lit_name = "";
   int          errs = 0;
   int          checks = 0;
   function automatic bit mvalid(input logic [11:0] a);
      return (a >= 12'h300 && a <= 12'h307) || (a >= 12'h340 && a <= 12'h347);
   endfunction
   function automatic int midx(input logic [11:0] a);
      return a < 12'h340 ? int'(a) - 'h300 : int'(a) - 'h340 + 8;
   endfunction
   function automatic logic [31:0] mrd(input logic [11:0] a);
      return mvalid(a) ? m[midx(a)] : 32'h0;
   endfunction
   task automatic model_step();
      logic [31:0] o, n;
      if (!rst) begin
         for (int i = 0; i < 16; i++) m[i] = 32'h0;
         m[0] = 32'h88;
         ready = 1;
      end else if (csr_w && mvalid(waddr)) begin
         o = m[midx(waddr)];
         case (csr_wsc_mode)
            2'd2: n = o | wdata;
            2'd3: n = o & ~wdata;
            default: n = wdata;
         endcase
`ifdef CSR_MSTATUS_MASK_EN
         if (waddr == 12'h300) n = n & 32'h1888;
`endif
         m[midx(waddr)] = n;
      end
   endtask
   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
      lit_on = 0;
   endtask
   task automatic st(input logic r, input logic w, input logic [11:0] wa, input logic [31:0] wd,
                     input logic [1:0] md, input logic [11:0] ra, input bit l,
                     input logic [31:0] lr, input logic [31:0] lm, input string nm);
      rst = r; csr_w = w; waddr = wa; wdata = wd; csr_wsc_mode = md; raddr = ra;
      lit_on = l; lit_rd = lr; lit_ms = lm; lit_name = nm;
      tick();
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %08h expected %08h (t=%0t raddr=%03h)", nm, act, exp, $time, raddr);
      end
   endtask
   always @(negedge clk) begin
      if (ready) begin
         chk("rdata_model", rdata, mrd(raddr));
         chk("mstatus_model", mstatus, m[0]);
         if (lit_on) begin
            chk({lit_name, "_rdata"}, rdata, lit_rd);
            chk({lit_name, "_mstatus"}, mstatus, lit_ms);
         end
      end
   end
   initial begin
      logic [11:0] a;
      st(0, 0, 12'h0, 32'h0, 2'd0, 12'h300, 0, 0, 0, "");
      st(0, 0, 12'h0, 32'h0, 2'd0, 12'h300, 0, 0, 0, "");
      st(1, 0, 12'h0, 32'h0, 2'd0, 12'h300, 1, 32'h88, 32'h88, "reset_mstatus");
      st(1, 0, 12'h0, 32'h0, 2'd0, 12'h341, 1, 32'h0, 32'h88, "reset_mepc");
      st(1, 1, 12'h305, 32'h100, 2'd0, 12'h305, 1, 32'h0, 32'h88, "mtvec_old");
      st(1, 0, 12'h305, 32'h0, 2'd0, 12'h305, 1, 32'h100, 32'h88, "mtvec_new");
      st(1, 1, 12'h342, 32'hB, 2'd1, 12'h342, 1, 32'h0, 32'h88, "mcause_old");
      st(1, 1, 12'h342, 32'h8000_0000, 2'd2, 12'h342, 1, 32'hB, 32'h88, "mcause_write");
      st(1, 1, 12'h342, 32'hB, 2'd3, 12'h342, 1, 32'h8000_000B, 32'h88, "mcause_set");
      st(1, 0, 12'h342, 32'h0, 2'd0, 12'h342, 1, 32'h8000_0000, 32'h88, "mcause_clr");
      st(1, 1, 12'h7FF, 32'hDEAD_BEEF, 2'd0, 12'h310, 0, 0, 0, "");
      st(1, 1, 12'h310, 32'hDEAD_BEEF, 2'd0, 12'h310, 0, 0, 0, "");
      st(1, 0, 12'h341, 32'hFFFF_FFFF, 2'd0, 12'h310, 1, 32'h0, 32'h88, "invalid_310");
      st(1, 0, 12'h341, 32'hFFFF_FFFF, 2'd0, 12'h341, 1, 32'h0, 32'h88, "no_we_mepc");
      st(1, 0, 12'h0, 32'h0, 2'd0, 12'h305, 1, 32'h100, 32'h88, "mtvec_kept");
      st(1, 1, 12'h300, 32'h1880, 2'd0, 12'h300, 1, 32'h88, 32'h88, "trap_old");
      st(1, 1, 12'h300, 32'h88, 2'd0, 12'h300, 1, 32'h1880, 32'h1880, "trap");
`ifdef CSR_MSTATUS_MASK_EN
      st(1, 1, 12'h300, 32'hFFFF_FFFF, 2'd0, 12'h300, 1, 32'h88, 32'h88, "mret");
      st(1, 0, 12'h300, 32'h0, 2'd0, 12'h300, 1, 32'h1888, 32'h1888, "mask_all");
`else
      st(1, 1, 12'h300, 32'hFFFF_FFFF, 2'd0, 12'h300, 1, 32'h88, 32'h88, "mret");
      st(1, 0, 12'h300, 32'h0, 2'd0, 12'h300, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "write_all");
`endif
      st(1, 1, 12'h341, 32'h5555, 2'd0, 12'h341, 0, 0, 0, "");
      st(0, 1, 12'h341, 32'h1234, 2'd0, 12'h341, 0, 0, 0, "");
      st(1, 0, 12'h341, 32'h0, 2'd0, 12'h341, 1, 32'h0, 32'h88, "rst_prio");
      for (int k = 0; k < 3000; k++) begin
         a = 12'($urandom_range(0, 1) ? 12'h340 : 12'h300) + 12'($urandom_range(0, 7));
         st($urandom_range(0, 99) != 0, $urandom_range(0, 1),
            $urandom_range(0, 3) == 0 ? 12'($urandom) : a, $urandom, 2'($urandom),
            $urandom_range(0, 3) == 0 ? 12'($urandom) : 12'($urandom_range(0, 1) ? 12'h340 : 12'h300) + 12'($urandom_range(0, 7)),
            0, 0, 0, "");
      end
      st(1, 0, 12'h0, 32'h0, 2'd0, 12'h308, 0, 0, 0, "");
      st(1, 0, 12'h0, 32'h0, 2'd0, 12'h348, 0, 0, 0, "");
      st(1, 0, 12'h0, 32'h0, 2'd0, 12'h380, 0, 0, 0, "");
      for (int k = 0; k < 16; k++)
         st(1, 0, 12'h0, 32'h0, 2'd0, (k < 8 ? 12'h300 : 12'h338) + 12'(k), 0, 0, 0, "");
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/csr_regs.md
CSR_REGS -- requirements
Module: csr_regs

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with port names as below.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  – single clock; all state updates on its rising edge.
- rst  in  1  – synchronous, active-low reset, sampled on the rising edge of clk.
- csr_w  in  1  – write enable.
- raddr  in  12  – read address.
- waddr  in  12  – write address.
- wdata  in  32  – write operand.
- csr_wsc_mode  in  2  – write mode.
- rdata  out  32  – read data.
- mstatus  out  32  – current mstatus contents, direct tap.

Function
REQ-003 Storage SHALL be 16 x 32-bit machine-mode CSRs.
REQ-004 An address SHALL be valid iff addr[11:7]==5'h06 and addr[5:3]==3'b000; index = {addr[6], addr[2:0]}.
- Valid ranges: 0x300–0x307 map to index 0–7; 0x340–0x347 map to index 8–15.
- Named slots: mstatus 0x300 (idx 0), mtvec 0x305 (idx 5), mepc 0x341 (idx 9), mcause 0x342 (idx 10), mtval 0x343 (idx 11), mip 0x344 (idx 12).
REQ-005 Read SHALL be purely combinational: rdata = reg[index(raddr)] for a valid raddr, otherwise 32'h0.
REQ-006 mstatus SHALL be driven combinationally from reg[0] at all times, independent of raddr.
REQ-007 A write SHALL occur on the rising edge of clk when rst==1, csr_w==1 and waddr is valid; write latency is one edge.
REQ-008 The write mode SHALL be selected by csr_wsc_mode:
- 2'b00 and 2'b01: replace, new = wdata.
- 2'b10: set, new = old | wdata.
- 2'b11: clear, new = old & ~wdata.
REQ-009 If csr_w==0 or waddr is invalid, no register SHALL change; writes to invalid addresses are silently dropped.
REQ-010 Read-during-write to the same address SHALL return the old value until the edge, with no bypass; the new value is visible combinationally after the edge.
REQ-011 Only one register SHALL be written per cycle; raddr and waddr are fully independent.

Reset
REQ-012 When rst==0 at a rising edge, the block SHALL load reset values, and reset SHALL take priority over any write in the same cycle.
- mstatus: 32'h0000_0088 (MIE=1, MPIE=1).
- All other registers: 32'h0.
REQ-013 Reset asserted mid-sequence (for example, between trap writes) SHALL discard all prior state.

Configuration
REQ-014 The macro CSR_MSTATUS_MASK_EN SHALL control masking of mstatus writes.
- Defined: every write to mstatus, in any mode, is masked with 32'h0000_1888 (MIE bit 3, MPIE bit 7, MPP bits 12:11); unmasked bits read 0.
- Not defined: mstatus stores all 32 bits like any other CSR.
- The reset value 0x88 SHALL be the same in both cases.

Structure
REQ-015 A shared package csr_pkg SHALL hold:
- CSR address localparams (0x300, 0x305, 0x341, 0x342, 0x343, 0x344).
- Write-mode encodings (WSC_WRITE, WSC_SET, WSC_CLR).
- The mstatus reset value and the mstatus write mask.
REQ-016 One sub-module csr_addr_decode SHALL map a 12-bit address to {valid, 4-bit index}.
- It SHALL be instantiated twice: once for raddr and once for waddr.

Verification
REQ-017 After reset: read 0x300 -> rdata = 0x00000088 and mstatus = 0x00000088; read 0x341 -> 0x0.
REQ-018 Replace write: csr_w=1, waddr=0x305, wdata=0x00000100, mode 00 -> raddr 0x305 reads 0x00000100 after the edge and the old value before it.
REQ-019 Set then clear on 0x342:
- Write 0x0000000B with mode 01 -> reads 0x0000000B.
- Set with 0x80000000 (mode 10) -> reads 0x8000000B.
- Clear with 0x0000000B (mode 11) -> reads 0x80000000.
REQ-020 Invalid addresses:
- Write 0x7FF (wdata 0xDEADBEEF), then write 0x310 -> no register changes; reading 0x310 returns 0x0.
- csr_w=0 with valid waddr=0x341 -> no change.
REQ-021 mstatus trap/return sequence:
- Write 0x00001880 to 0x300 -> mstatus output = 0x00001880 the same cycle after the edge.
- Write 0x88 -> output = 0x88.
- With CSR_MSTATUS_MASK_EN defined: writing 0xFFFFFFFF yields 0x00001888.
REQ-022 Reset priority: rst=0 together with csr_w=1, waddr=0x341, wdata=0x1234 -> mepc = 0x0 and mstatus = 0x88.
